// File: rtl/calc_seq_if.sv
// Handshake and operand/result bundle between the operand-entry logic and calc_seq.
interface calc_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic [1:0]             op;
    logic                   chain;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, op, chain, a, b,
        input  busy, done, err, result
    );

    modport slave (
        input  start, op, chain, a, b,
        output busy, done, err, result
    );
endinterface

// File: rtl/calc_seq.sv
// Sequential add / subtract / shift-add multiply unit with a start/busy/done handshake
// and a chain mode that reuses the low half of the previous result as operand A.
module calc_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    calc_seq_if.slave   bus
);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned PW = RW + 1;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ALU  = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [PW-1:0]      r_p;
    logic [CW-1:0]      r_cnt;
    logic [RW-1:0]      r_result;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH:0]     w_upper;
    logic [PW-1:0]      w_p_next;
    logic [RW-1:0]      w_alu;

    assign w_opa = bus.chain ? r_result[WIDTH-1:0] : bus.a;

    // One multiply step: conditionally add A into the upper part, then shift right.
    assign w_upper  = r_p[PW-1:WIDTH] + (r_p[0] ? (WIDTH+1)'(r_a) : (WIDTH+1)'(0));
    assign w_p_next = {1'b0, w_upper, r_p[WIDTH-1:1]};

    assign w_alu = (r_op == OP_SUB) ? (RW'(r_a) - RW'(r_b))
                                    : (RW'(r_a) + RW'(r_b));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op <= bus.op;
                        r_a  <= w_opa;
                        r_b  <= bus.b;
                        if (bus.op == OP_MUL) begin
                            r_p     <= {(WIDTH+1)'(0), bus.b};
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
                        end else if (bus.op == OP_ADD || bus.op == OP_SUB) begin
                            r_busy  <= 1'b1;
                            r_state <= S_ALU;
                        end else begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                end
                S_ALU: begin
                    r_result <= w_alu;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_MUL: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result <= w_p_next[RW-1:0];
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;
endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq at WIDTH=8: arithmetic, chaining, handshake timing and reset abort.
module tb_calc_seq;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    calc_seq_if #(.WIDTH(W)) bus ();

    calc_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request so that the next rising edge is the start edge E0.
    task automatic issue(input logic [1:0] op_i, input logic [W-1:0] a_i,
                         input logic [W-1:0] b_i, input logic ch);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        bus.chain = ch;
        tick();
        bus.start = 1'b0;
        bus.chain = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b err=%b result=%h exp 0 0 0 0000",
                     bus.busy, bus.done, bus.err, bus.result);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        issue(2'b00, 8'hFF, 8'hFF, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL add_e0 got busy=%b done=%b exp 1 0", bus.busy, bus.done);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 16'h01FE) begin
            errors++;
            $display("FAIL add_e1 got done=%b busy=%b result=%h exp 1 0 01fe",
                     bus.done, bus.busy, bus.result);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL add_done_pulse got done=%b err=%b exp 0 0", bus.done, bus.err);
        end
    endtask

    task automatic test_sub_back_to_back();
        issue(2'b01, 8'd3, 8'd5, 1'b0);
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'hFFFE) begin
            errors++;
            $display("FAIL sub_borrow got done=%b result=%h exp 1 fffe", bus.done, bus.result);
        end
        // Issue the next subtract while done is still high.
        issue(2'b01, 8'd9, 8'd4, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.result !== 16'hFFFE) begin
            errors++;
            $display("FAIL sub_b2b_accept got busy=%b result=%h exp 1 fffe", bus.busy, bus.result);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0005) begin
            errors++;
            $display("FAIL sub_plain got done=%b result=%h exp 1 0005", bus.done, bus.result);
        end
        tick();
    endtask

    task automatic test_mul();
        int n;
        issue(2'b10, 8'hFF, 8'hFF, 1'b0);
        n = 0;
        for (int i = 0; i < 20 && bus.done !== 1'b1; i++) begin
            if (bus.busy === 1'b1) n++;
            tick();
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL mul_timeout got done=%b exp 1", bus.done);
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL mul_busy_cycles got %0d exp 8", n);
        end
        checks++;
        if (bus.result !== 16'hFE01) begin
            errors++;
            $display("FAIL mul_ff_ff got %h exp fe01", bus.result);
        end
        tick();
        issue(2'b10, 8'h00, 8'hAB, 1'b0);
        for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0000) begin
            errors++;
            $display("FAIL mul_zero got done=%b result=%h exp 1 0000", bus.done, bus.result);
        end
        tick();
    endtask

    task automatic test_chain();
        issue(2'b00, 8'd2, 8'd3, 1'b0);
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0005) begin
            errors++;
            $display("FAIL chain_seed got done=%b result=%h exp 1 0005", bus.done, bus.result);
        end
        // Chained start right on the done cycle: A must come from result, not from a.
        issue(2'b10, 8'h55, 8'd7, 1'b1);
        for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0023) begin
            errors++;
            $display("FAIL chain_mul got done=%b result=%h exp 1 0023", bus.done, bus.result);
        end
        tick();
    endtask

    task automatic test_protocol();
        int pulses;
        issue(2'b10, 8'd12, 8'd13, 1'b0);
        tick();
        tick();
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        tick();
        bus.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_start_pulses got %0d exp 1", pulses);
        end
        checks++;
        if (bus.result !== 16'h009C) begin
            errors++;
            $display("FAIL ignore_start_result got %h exp 009c", bus.result);
        end
        issue(2'b11, 8'h12, 8'h34, 1'b0);
        checks++;
        if ({bus.done, bus.err, bus.busy} !== 3'b110 || bus.result !== 16'h009C) begin
            errors++;
            $display("FAIL illegal_op got done=%b err=%b busy=%b result=%h exp 1 1 0 009c",
                     bus.done, bus.err, bus.busy, bus.result);
        end
        tick();
        checks++;
        if ({bus.done, bus.err, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL illegal_pulse got done=%b err=%b busy=%b exp 0 0 0",
                     bus.done, bus.err, bus.busy);
        end
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        issue(2'b10, 8'h10, 8'h10, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_abort got busy=%b done=%b err=%b result=%h exp 0 0 0 0000",
                     bus.busy, bus.done, bus.err, bus.result);
        end
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d active cycles exp 0", pulses);
        end
        issue(2'b00, 8'd1, 8'd2, 1'b0);
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0003) begin
            errors++;
            $display("FAIL post_reset_add got done=%b result=%h exp 1 0003", bus.done, bus.result);
        end
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.chain = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        test_reset();
        test_add();
        test_sub_back_to_back();
        test_mul();
        test_chain();
        test_protocol();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
